ps2_rx_frame: RTL
=================

# ps2_rx_frame

Parametrised PS/2 device-to-host frame receiver. It replaces the plain shift-in receiver with several additions:
- synchronisers on both PS/2 lines and a glitch filter of configurable length;
- full 11-bit frame validation (start, odd parity, stop);
- an inter-bit watchdog that abandons stalled frames;
- a show-ahead scan-code FIFO with a valid/ready interface.

It sits between the keyboard/mouse pins and the input-decoding logic of the game controller.

## Interface
Parameters:
- FILTER_LEN, default 8: glitch-filter length in clk_i cycles (≥2).
- TIMEOUT_CYCLES, default 100000: maximum clk_i cycles between falling edges inside a frame (≥2).
- FIFO_DEPTH, default 4: scan-code FIFO entries (power of two, ≥2).

Ports (one clock; reset is asynchronous and active-low):
- clk_i, input, 1: system clock.
- reset_ni, input, 1: asynchronous active-low reset.
- rx_en_i, input, 1: permits a new frame to start; sampled only in IDLE.
- ps2c_i, input, 1: raw PS/2 clock pin.
- ps2d_i, input, 1: raw PS/2 data pin.
- rx_data_o, output, 8: FIFO head byte; 0 when empty after reset.
- rx_valid_o, output, 1: FIFO non-empty.
- rx_ready_i, input, 1: consumer accepts the head byte when rx_valid_o=1.
- parity_err_o, output, 1: one-cycle pulse, frame dropped because of bad parity.
- frame_err_o, output, 1: one-cycle pulse, frame dropped because stop bit = 0.
- timeout_o, output, 1: one-cycle pulse, frame abandoned by the watchdog.
- overflow_o, output, 1: one-cycle pulse, good frame dropped because the FIFO was full.
- busy_o, output, 1: state ≠ IDLE.

## Operation
- **Input conditioning**
  - ps2c_i and ps2d_i each pass through a 2-flop synchroniser; both reset to 1.
  - Synchronised clock shifts into a FILTER_LEN-bit register (reset all ones).
  - Filtered clock goes to 1 on all-ones and to 0 on all-zeros; otherwise it holds (reset 1).
  - fall = filtered_reg & ~filtered_next. The data bit is the synchronised ps2d value in that cycle.
- **State machine: IDLE, DATA, CHECK**
  - IDLE: on fall with rx_en_i=1 and data=0 (start bit): clear shift register, bit_cnt=0, clear watchdog, go to DATA. A fall with data=1 is ignored. Any fall with rx_en_i=0 is ignored.
  - DATA: on each fall, shift the data bit into a 10-bit register LSB-first (8 data, parity, stop), increment bit_cnt, clear watchdog. When bit_cnt reaches 9 on a fall, go to CHECK.
    - With no fall, the watchdog increments. At TIMEOUT_CYCLES-1 it pulses timeout_o and returns to IDLE, discarding partial data.
  - CHECK (exactly one cycle, always returns to IDLE):
    - stop=0 → frame_err_o.
    - else XOR(data, parity)=0 → parity_err_o.
    - else push the byte. If the FIFO is full and there is no pop this cycle, drop the byte and pulse overflow_o.
    - Stop-bit failure takes priority; only one error pulses per frame.
- Deasserting rx_en_i mid-frame does not abort a frame already in progress.
- **FIFO**
  - Circular buffer; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Count is $clog2(FIFO_DEPTH)+1 bits.
  - Pop occurs when rx_valid_o & rx_ready_i.
  - Push and pop in the same cycle: always accepted, count unchanged, including when full.
  - Pop on empty is ignored. rx_data_o shows the head entry combinationally from memory.
- Reset mid-frame: every register returns to its reset value, the FIFO empties, and partial data is lost.

## Timing
- Reset values: rx_data_o=0, rx_valid_o=0, all error pulses 0, busy_o=0, state=IDLE.
- Pin-to-fall latency: 2 sync cycles plus FILTER_LEN cycles after ps2c_i settles low.
- Let the stop-bit fall be in cycle N:
  - CHECK is in cycle N+1.
  - Error/overflow pulses and the FIFO write are registered at the end of N+1, so they are visible in N+2.
  - rx_valid_o rises in N+2 if the FIFO was empty.
- Pop at the end of cycle M: the new head or rx_valid_o=0 is visible in M+1.
- Pulses last exactly one cycle. At most one frame completes per ≥11·FILTER_LEN cycles, so pulses never merge.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, DATA, CHECK);
  - constants FRAME_BITS=11 and PAYLOAD_BITS=8;
  - a function odd_parity_ok(data, parity).
- Sub-module ps2_rx_fifo: parametrised show-ahead FIFO (DATA_W, DEPTH) with push/full/pop/empty. It is reused later by the host-to-device transmitter path.
- The top level contains the synchronisers, filter, FSM, watchdog and status pulse registers.

## Test plan
- **Good frame:** send 0x1C with parity 0 and stop 1, FIFO_DEPTH=4, rx_ready_i=1. Expect rx_valid_o for 1 cycle with rx_data_o=0x1C at N+2 and no error pulses.
- **Bad parity:** send 0x1C with parity 1. Expect parity_err_o pulse at N+2 and rx_valid_o to stay 0. Then send 0xF0 with parity 1; expect 0xF0 to be accepted.
- **Bad stop and bad parity together:** send 0x1C with stop 0 and parity 1. Expect only frame_err_o.
- **Watchdog:** TIMEOUT_CYCLES=50; stop ps2c_i after 4 bits. Expect timeout_o 50 cycles after the last fall and busy_o=0. A following 0x29 frame must be received intact.
- **Overflow and simultaneous push/pop:** rx_ready_i=0, send 0x01..0x05. Expect 4 entries queued and overflow_o on 0x05. Drain to get 0x01..0x04 in order. Refill to full, then hold rx_ready_i=1 during CHECK of 0x06; expect no overflow and count unchanged.
- **Glitch and reset:** a ps2c_i low pulse of FILTER_LEN-1 cycles yields no bit. Asserting reset_ni=0 mid-frame clears busy_o, rx_valid_o and the FIFO immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
//   ps2_state_e   : receiver FSM states
//   FRAME_BITS    : start + 8 data + parity + stop
//   PAYLOAD_BITS  : scan-code width
//   odd_parity_ok : 1 when data plus parity carry an odd number of ones
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } ps2_state_e;

   localparam int FRAME_BITS   = 11;
   localparam int PAYLOAD_BITS = 8;

   function automatic logic odd_parity_ok(input logic [PAYLOAD_BITS-1:0] data,
                                          input logic                    parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead circular FIFO.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   push_i          : write push_data_i (ignored when full unless popping the same cycle)
//   full_o          : all DEPTH entries occupied
//   pop_i           : drop the head entry (ignored when empty)
//   empty_o         : no entries
//   pop_data_o      : head entry, read combinationally from storage
module ps2_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   output logic              full_o,
   input  logic              pop_i,
   output logic              empty_o,
   output logic [DATA_W-1:0] pop_data_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push;
   logic              do_pop;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == FULL_CNT);
   assign do_pop     = pop_i & ~empty_o;
   // A pop frees the slot the push needs, so push+pop on a full FIFO is accepted.
   assign do_push    = push_i & (~full_o | do_pop);
   assign pop_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with input filtering, frame checks,
// inter-bit watchdog and a scan-code FIFO.
//   clk_i, reset_ni   : clock, asynchronous active-low reset
//   rx_en_i           : allows a new frame to start (looked at in IDLE only)
//   ps2c_i, ps2d_i    : raw PS/2 clock and data pins
//   rx_data_o         : FIFO head byte
//   rx_valid_o        : FIFO not empty
//   rx_ready_i        : consumer takes the head byte when rx_valid_o=1
//   parity_err_o      : pulse, frame dropped for bad parity
//   frame_err_o       : pulse, frame dropped for stop bit = 0
//   timeout_o         : pulse, frame abandoned by the watchdog
//   overflow_o        : pulse, good frame dropped because the FIFO was full
//   busy_o            : receiver not in IDLE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a start-bit fall while rx_en_i=1
// DATA  | shifting data, parity and stop bits; watchdog running
// CHECK | one cycle: validate stop/parity, push byte or flag error
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       rx_en_i,
   input  logic       ps2c_i,
   input  logic       ps2d_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       timeout_o,
   output logic       overflow_o,
   output logic       busy_o
);

   localparam int SHIFT_W   = FRAME_BITS - 1;
   localparam int WD_W      = $clog2(TIMEOUT_CYCLES);
   localparam int WD_LAST_I = TIMEOUT_CYCLES - 1;
   localparam logic [WD_W-1:0] WD_LAST  = WD_LAST_I[WD_W-1:0];
   localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 2);

   logic                  c_meta_q, c_sync_q;
   logic                  d_meta_q, d_sync_q;
   logic [FILTER_LEN-1:0] filt_sr_q;
   logic                  filt_q, filt_d;
   logic                  fall;

   ps2_state_e            state_q, state_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [SHIFT_W-1:0]    shift_q, shift_d;
   logic [WD_W-1:0]       wd_q, wd_d;

   logic                  perr_d, ferr_d, to_d, ovf_d;
   logic                  perr_q, ferr_q, to_q, ovf_q;
   logic                  push;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;

   // Filtered clock only moves once the whole window agrees.
   always_comb begin
      filt_d = filt_q;
      if (&filt_sr_q) begin
         filt_d = 1'b1;
      end else if (~|filt_sr_q) begin
         filt_d = 1'b0;
      end
   end

   assign fall = filt_q & ~filt_d;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      wd_d      = wd_q;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      to_d      = 1'b0;
      push      = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall && rx_en_i && !d_sync_q) begin
               shift_d   = '0;
               bit_cnt_d = '0;
               wd_d      = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (fall) begin
               // LSB-first: after ten shifts [7:0]=data, [8]=parity, [9]=stop.
               shift_d   = {d_sync_q, shift_q[SHIFT_W-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               wd_d      = '0;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = CHECK;
               end
            end else if (wd_q == WD_LAST) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (!shift_q[SHIFT_W-1]) begin
               ferr_d = 1'b1;
            end else if (!odd_parity_ok(shift_q[PAYLOAD_BITS-1:0], shift_q[PAYLOAD_BITS])) begin
               perr_d = 1'b1;
            end else begin
               push = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop   = rx_valid_o & rx_ready_i;
   assign ovf_d = push & fifo_full & ~pop;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         c_meta_q  <= 1'b1;
         c_sync_q  <= 1'b1;
         d_meta_q  <= 1'b1;
         d_sync_q  <= 1'b1;
         filt_sr_q <= '1;
         filt_q    <= 1'b1;
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         wd_q      <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         to_q      <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         c_meta_q  <= ps2c_i;
         c_sync_q  <= c_meta_q;
         d_meta_q  <= ps2d_i;
         d_sync_q  <= d_meta_q;
         filt_sr_q <= {filt_sr_q[FILTER_LEN-2:0], c_sync_q};
         filt_q    <= filt_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         wd_q      <= wd_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         to_q      <= to_d;
         ovf_q     <= ovf_d;
      end
   end

   ps2_rx_fifo #(
      .DATA_W (PAYLOAD_BITS),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .push_i      (push),
      .push_data_i (shift_q[PAYLOAD_BITS-1:0]),
      .full_o      (fifo_full),
      .pop_i       (pop),
      .empty_o     (fifo_empty),
      .pop_data_o  (rx_data_o)
   );

   assign rx_valid_o   = ~fifo_empty;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign timeout_o    = to_q;
   assign overflow_o   = ovf_q;
   assign busy_o       = (state_q != IDLE);

endmodule
